// File: rtl/playlist_controller.sv
// Playlist controller: selects the current song, runs play/pause, cycles
// through four playback modes and inserts a silent gap before auto-resume.
module playlist_controller #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_BITS  = 2,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 prev_button,
  input  logic                 mode_button,
  input  logic                 song_done,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song,
  output logic [1:0]           mode,
  output logic                 gap_active
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_PAUSED  = 2'd0;
  localparam logic [1:0] S_PLAYING = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;

  localparam logic [1:0] M_SINGLE     = 2'd0;
  localparam logic [1:0] M_REPEAT_ONE = 2'd1;
  localparam logic [1:0] M_SEQUENTIAL = 2'd2;
  localparam logic [1:0] M_LOOP_ALL   = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [SONG_BITS-1:0] song_nxt, song_inc, song_dec;
  logic [1:0]           mode_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;
  logic                 rp_nxt;

  assign song_inc = (song == LAST_SONG) ? '0 : song + SONG_BITS'(1);
  assign song_dec = (song == '0) ? LAST_SONG : song - SONG_BITS'(1);

  assign play       = (state == S_PLAYING);
  assign gap_active = (state == S_GAP);

  // Next-state decode: one event per cycle in priority order play > next >
  // prev > mode > song_done; the gap countdown runs whenever no state-changing
  // button pre-empts it.
  always_comb begin
    state_nxt = state;
    song_nxt  = song;
    mode_nxt  = mode;
    gap_nxt   = gap_cnt;
    rp_nxt    = 1'b0;
    if (play_button) begin
      state_nxt = (state == S_PAUSED) ? S_PLAYING : S_PAUSED;
    end else if (next_button) begin
      song_nxt = song_inc;
      rp_nxt   = 1'b1;
      if (state == S_GAP) state_nxt = S_PAUSED;
    end else if (prev_button) begin
      song_nxt = song_dec;
      rp_nxt   = 1'b1;
      if (state == S_GAP) state_nxt = S_PAUSED;
    end else begin
      if (mode_button) begin
        mode_nxt = mode + 2'd1;
      end else if (song_done && state == S_PLAYING) begin
        rp_nxt = 1'b1;
        case (mode)
          M_SINGLE:     state_nxt = S_PAUSED;
          M_REPEAT_ONE: begin
            state_nxt = S_GAP;
            gap_nxt   = GAP_LOAD;
          end
          M_SEQUENTIAL: begin
            if (song == LAST_SONG) begin
              song_nxt  = '0;
              state_nxt = S_PAUSED;
            end else begin
              song_nxt  = song + SONG_BITS'(1);
              state_nxt = S_GAP;
              gap_nxt   = GAP_LOAD;
            end
          end
          M_LOOP_ALL: begin
            song_nxt  = song_inc;
            state_nxt = S_GAP;
            gap_nxt   = GAP_LOAD;
          end
          default: state_nxt = S_PAUSED;
        endcase
      end
      // Silence lasts GAP_CYCLES cycles: the cycle the counter reads 0 is the last.
      if (state == S_GAP) begin
        if (gap_cnt == '0) state_nxt = S_PLAYING;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
    end
  end

  // Register all controller state; reset never produces a reset_player pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_PAUSED;
      song         <= '0;
      mode         <= M_SINGLE;
      gap_cnt      <= '0;
      reset_player <= 1'b0;
    end else begin
      state        <= state_nxt;
      song         <= song_nxt;
      mode         <= mode_nxt;
      gap_cnt      <= gap_nxt;
      reset_player <= rp_nxt;
    end
  end

endmodule

// File: tb/tb_playlist_controller.sv
// Bench for playlist_controller (3 songs, 4-cycle gap). A reference model
// predicts each cycle's outputs, which are queued at drive time and compared
// after the clock edge; a few directed checks pin down the key scenarios.
module tb_playlist_controller;

  localparam int NS  = 3;
  localparam int SB  = 2;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset, play_button, next_button, prev_button, mode_button, song_done;
  logic play, reset_player, gap_active;
  logic [SB-1:0] song;
  logic [1:0] mode;

  playlist_controller #(.NUM_SONGS(NS), .SONG_BITS(SB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .mode_button(mode_button), .song_done(song_done), .play(play),
    .reset_player(reset_player), .song(song), .mode(mode),
    .gap_active(gap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int play; int rp; int song; int mode; int gap;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 paused, 1 playing, 2 gap
  int m_state, m_song, m_mode, m_gcnt, m_rp;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge given the driven inputs.
  task automatic model(input bit rst, input bit pb, input bit nb, input bit prb,
                       input bit mb, input bit sd);
    int st0;
    st0 = m_state;
    m_rp = 0;
    if (rst) begin
      m_state = 0; m_song = 0; m_mode = 0; m_gcnt = 0;
      return;
    end
    if (pb) begin
      m_state = (st0 == 0) ? 1 : 0;
    end else if (nb || prb) begin
      if (nb) m_song = (m_song + 1) % NS;
      else    m_song = (m_song + NS - 1) % NS;
      m_rp = 1;
      if (st0 == 2) m_state = 0;
    end else begin
      if (mb) m_mode = (m_mode + 1) % 4;
      else if (sd && st0 == 1) begin
        m_rp = 1;
        if (m_mode == 0) m_state = 0;
        else if (m_mode == 1) begin m_state = 2; m_gcnt = GAP - 1; end
        else if (m_mode == 2) begin
          if (m_song == NS - 1) begin m_song = 0; m_state = 0; end
          else begin m_song++; m_state = 2; m_gcnt = GAP - 1; end
        end else begin
          m_song = (m_song + 1) % NS; m_state = 2; m_gcnt = GAP - 1;
        end
      end
      if (st0 == 2) begin
        if (m_gcnt == 0) m_state = 1;
        else m_gcnt--;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, then compare after the edge.
  task automatic cyc(input bit rst, input bit pb, input bit nb, input bit prb,
                     input bit mb, input bit sd);
    exp_t e, g;
    @(negedge clk);
    reset = rst; play_button = pb; next_button = nb; prev_button = prb;
    mode_button = mb; song_done = sd;
    model(rst, pb, nb, prb, mb, sd);
    e.play = (m_state == 1); e.rp = m_rp; e.song = m_song; e.mode = m_mode;
    e.gap = (m_state == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      g = sb.pop_front();
      check("play", int'(play), g.play);
      check("reset_player", int'(reset_player), g.rp);
      check("song", int'(song), g.song);
      check("mode", int'(mode), g.mode);
      check("gap_active", int'(gap_active), g.gap);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; play_button = 0; next_button = 0; prev_button = 0;
    mode_button = 0; song_done = 0;
    m_state = 0; m_song = 0; m_mode = 0; m_gcnt = 0; m_rp = 0;

    // 1: reset values, then play
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    check("rst_song", int'(song), 0);
    check("rst_play", int'(play), 0);
    check("rst_rp", int'(reset_player), 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("play_on", int'(play), 1);

    // 2: next wraps at last song, prev wraps at song 0
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    check("song_two", int'(song), 2);
    cyc(0, 0, 1, 0, 0, 0);
    check("next_wrap_song", int'(song), 0);
    check("next_wrap_pulse", int'(reset_player), 1);
    check("next_wrap_play", int'(play), 1);
    idle(1);
    check("pulse_one_cycle", int'(reset_player), 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("prev_wrap_song", int'(song), 2);

    // 3: LOOP_ALL from song 1 -> song 2, 4-cycle gap, resume
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    check("mode_loop", int'(mode), 3);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("loop_song", int'(song), 2);
    check("loop_gap", int'(gap_active), 1);
    idle(3);
    check("gap_last", int'(play), 0);
    idle(1);
    check("gap_resume", int'(play), 1);

    // 4: SEQUENTIAL at last song -> song 0, paused
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    check("mode_seq", int'(mode), 2);
    cyc(0, 0, 0, 0, 0, 1);
    check("seq_song", int'(song), 0);
    check("seq_pause", int'(play), 0);
    check("seq_pulse", int'(reset_player), 1);
    //    REPEAT_ONE: song held, gap, resume
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("rep_song", int'(song), 1);
    check("rep_gap", int'(gap_active), 1);
    idle(GAP + 1);

    // 5: play+next together -> pause only; song_done while paused ignored
    cyc(0, 1, 1, 0, 0, 0);
    check("prio_pause", int'(play), 0);
    check("prio_song", int'(song), 1);
    check("prio_nopulse", int'(reset_player), 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("done_paused", int'(reset_player), 0);

    // 6: play during gap aborts resume; reset mid-gap
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); idle(1);
    cyc(0, 1, 0, 0, 0, 0);
    check("gap_abort", int'(gap_active), 0);
    idle(GAP + 2);
    check("no_resume", int'(play), 0);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 1); idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_gap_mode", int'(mode), 0);
    check("rst_gap_gap", int'(gap_active), 0);
    check("rst_gap_rp", int'(reset_player), 0);

    // random mix of events against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
